noc_config_filereg_arbiter: RTL and testbench
=============================================

Name: noc_config_filereg_arbiter

Overview:
Arbitrates between NumRequesters configuration-message sources for the single configuration FileReg port of a router tile. Typical sources are the local NI configuration target and network configuration-VN ejection. Each granted 39-bit request message is decoded (cmd[38:37], reg[36:32], payload[31:0]) and sequenced as one write or read access on the FileReg port. Read data is returned to the originating requester as a 43-bit response: module address [42:32], data [31:0].

Parameters:
NumRequesters, 2, number of request sources (≥1)
NumRegisters, 16, implemented registers; reg addresses ≥ NumRegisters are out of range
ReadLatency, 1, cycles from filereg_re_o pulse to valid filereg_rdata_i (1..7)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
module_addr_i  in  11  this tile's module address, placed in response [42:32]
req_valid_i  in  NumRequesters  request valid per requester
req_data_i  in  NumRequesters*39  request messages; requester k occupies bits [39k+38:39k]
req_ready_o  out  NumRequesters  one-hot accept
resp_valid_o  out  NumRequesters  one-hot response valid
resp_ready_i  in  NumRequesters  response ready per requester
resp_data_o  out  43  response message, shared by all requesters
filereg_we_o  out  1  write strobe
filereg_re_o  out  1  read strobe
filereg_addr_o  out  5  register address
filereg_wdata_o  out  32  write data
filereg_rdata_i  in  32  read data
busy_o  out  1  high in any state other than IDLE
err_o  out  1  one-cycle pulse on an illegal command or out-of-range address

Behaviour:
- Reset values: all outputs 0; FSM enters IDLE; round-robin pointer resets to 0.
- Commands: 2'b00 = write, 2'b01 = read, 2'b1x = illegal.
- IDLE:
  - Combinational round-robin grant, starting the search at the pointer.
  - req_ready_o[g] = 1 only for winner g, only in IDLE.
  - On accept (valid & ready): latch the message and g; pointer <= (g+1) mod NumRequesters; next state ISSUE.
- ISSUE (exactly 1 cycle): addr/wdata driven from the latched message.
  - Legal write, in range: filereg_we_o = 1; next state IDLE.
  - Legal read, in range: filereg_re_o = 1; next state WAIT.
  - Out-of-range write: no strobe; err_o pulse; next state IDLE.
  - Out-of-range read: no strobe; err_o pulse; response data forced to 0; next state RESP.
  - Illegal command: no strobe; err_o pulse; next state IDLE (message consumed, no response).
- WAIT: counts ReadLatency cycles, then captures filereg_rdata_i and moves to RESP.
  - Capture cycle = re cycle + ReadLatency.
- RESP:
  - resp_valid_o[g] = 1; resp_data_o = {module_addr_i captured at ISSUE, data}.
  - Response held stable until resp_ready_i[g]; then next state IDLE.
  - resp_ready_i of other requesters is ignored.
- Latency:
  - Write: accept → we at +1 cycle; next accept possible at +2.
  - Read: accept → resp_valid at +2+ReadLatency.
- Strobes are single-cycle and mutually exclusive; the FileReg port is never accessed outside ISSUE.
- No new accept while busy, so one access is outstanding at most.
- Reset mid-operation: any pending strobe or response is dropped immediately; no partial access is retried.
- A requester that deasserts valid before its grant is not granted; the grant recomputes each IDLE cycle.
- NumRequesters = 1: the pointer stays at 0.

Optional Feature:
NOC_CONFIG_FILEREG_WRITE_ACK_EN
- Defined:
  - In-range writes go ISSUE → RESP and return an ack response, data = written payload.
  - Out-of-range writes also return a response, data = 32'h0.
- Undefined: writes produce no response, as described above.

Test Plan:
- Requester 0 sends write reg 3, payload 0xCAFE0001 → we=1, addr=3, wdata=0xCAFE0001 one cycle after accept; no resp_valid_o.
- Write then read reg 3 from requester 1, module_addr_i=0x155, ReadLatency=2 → resp_valid_o=2'b10, resp_data_o={0x155,0xCAFE0001} 4 cycles after read accept.
- Both requesters hold valid reads continuously → grants alternate 0,1,0,1; each response is held until its own resp_ready_i.
- Read reg 20 (out of range) → no re strobe, err_o pulse, response data 0; cmd 2'b10 → err_o pulse, no strobe, no response.
- Assert rst_i during WAIT → all outputs 0 same cycle; after release, a fresh request is granted starting at requester 0.
- With NOC_CONFIG_FILEREG_WRITE_ACK_EN, write reg 5 payload 0x12345678 → response {module_addr_i, 0x12345678} after the we strobe.

Source files
------------

// File: rtl/noc_config_filereg_arbiter_if.sv
// Request/response and FileReg port bundle for noc_config_filereg_arbiter.
// slave = arbiter side, master = sources/FileReg side.
interface noc_config_filereg_arbiter_if #(
  parameter int NumRequesters = 2
);
  logic [NumRequesters-1:0]    req_valid_i;
  logic [NumRequesters*39-1:0] req_data_i;
  logic [NumRequesters-1:0]    req_ready_o;
  logic [NumRequesters-1:0]    resp_valid_o;
  logic [NumRequesters-1:0]    resp_ready_i;
  logic [42:0]                 resp_data_o;
  logic                        filereg_we_o;
  logic                        filereg_re_o;
  logic [4:0]                  filereg_addr_o;
  logic [31:0]                 filereg_wdata_o;
  logic [31:0]                 filereg_rdata_i;

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  resp_ready_i,
    input  filereg_rdata_i,
    output req_ready_o,
    output resp_valid_o,
    output resp_data_o,
    output filereg_we_o,
    output filereg_re_o,
    output filereg_addr_o,
    output filereg_wdata_o
  );

  modport master (
    output req_valid_i,
    output req_data_i,
    output resp_ready_i,
    output filereg_rdata_i,
    input  req_ready_o,
    input  resp_valid_o,
    input  resp_data_o,
    input  filereg_we_o,
    input  filereg_re_o,
    input  filereg_addr_o,
    input  filereg_wdata_o
  );
endinterface

// File: rtl/noc_config_filereg_arbiter.sv
// Round-robin arbiter sequencing config messages onto the FileReg port.
// Optional: NOC_CONFIG_FILEREG_WRITE_ACK_EN returns a response for writes.
module noc_config_filereg_arbiter #(
  parameter int NumRequesters = 2,
  parameter int NumRegisters  = 16,
  parameter int ReadLatency   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [10:0] module_addr_i,
  noc_config_filereg_arbiter_if.slave bus,
  output logic        busy_o,
  output logic        err_o
);
  localparam int PW = (NumRequesters > 1) ?
    $clog2(NumRequesters) : 1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_q;
  logic [PW-1:0] win;
  logic          win_vld;
  logic [38:0]   win_msg;
  logic [1:0]    win_cmd;
  logic [4:0]    win_reg;
  logic          win_in_range;
  logic [1:0]    cmd_q;
  logic          in_range_q;
  logic [2:0]    lat_cnt;
  logic          resp_vld_q;

  // round-robin search starting at the pointer
  always_comb begin
    int k;
    k       = 0;
    win     = '0;
    win_vld = 1'b0;
    win_msg = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NumRequesters) k = k - NumRequesters;
      if (!win_vld && bus.req_valid_i[k]) begin
        win_vld = 1'b1;
        win     = PW'(k);
        win_msg = bus.req_data_i[k*39 +: 39];
      end
    end
  end

  assign win_cmd      = win_msg[38:37];
  assign win_reg      = win_msg[36:32];
  assign win_in_range = int'({27'd0, win_reg}) < NumRegisters;

  // one-hot accept, only while idle and out of reset
  always_comb begin
    bus.req_ready_o = '0;
    if (state == IDLE && win_vld && !rst_i)
      bus.req_ready_o[win] = 1'b1;
  end

  // response valid is steered to the latched requester
  always_comb begin
    bus.resp_valid_o = '0;
    if (resp_vld_q)
      bus.resp_valid_o[gnt_q] = 1'b1;
  end

  assign busy_o = (state != IDLE);

  // access sequencer: accept, strobe, wait for read data, respond
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      gnt_q               <= '0;
      cmd_q               <= '0;
      in_range_q          <= 1'b0;
      lat_cnt             <= '0;
      resp_vld_q          <= 1'b0;
      err_o               <= 1'b0;
      bus.resp_data_o     <= '0;
      bus.filereg_we_o    <= 1'b0;
      bus.filereg_re_o    <= 1'b0;
      bus.filereg_addr_o  <= '0;
      bus.filereg_wdata_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            state               <= ISSUE;
            gnt_q               <= win;
            rr_ptr              <= (win == PW'(NumRequesters - 1)) ?
                                   '0 : win + 1'b1;
            cmd_q               <= win_cmd;
            in_range_q          <= win_in_range;
            bus.filereg_addr_o  <= win_reg;
            bus.filereg_wdata_o <= win_msg[31:0];
            bus.filereg_we_o    <= (win_cmd == 2'b00) && win_in_range;
            bus.filereg_re_o    <= (win_cmd == 2'b01) && win_in_range;
            err_o               <= win_cmd[1] || !win_in_range;
          end
        end
        ISSUE: begin
          bus.filereg_we_o        <= 1'b0;
          bus.filereg_re_o        <= 1'b0;
          err_o                   <= 1'b0;
          bus.resp_data_o[42:32]  <= module_addr_i;
          if (cmd_q == 2'b01 && in_range_q) begin
            state   <= WAIT;
            lat_cnt <= 3'd1;
          end else if (cmd_q == 2'b01) begin
            state                 <= RESP;
            resp_vld_q            <= 1'b1;
            bus.resp_data_o[31:0] <= '0;
`ifdef NOC_CONFIG_FILEREG_WRITE_ACK_EN
          end else if (cmd_q == 2'b00) begin
            state                 <= RESP;
            resp_vld_q            <= 1'b1;
            bus.resp_data_o[31:0] <= in_range_q ?
                                     bus.filereg_wdata_o : '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (lat_cnt == 3'(ReadLatency)) begin
            state                 <= RESP;
            resp_vld_q            <= 1'b1;
            bus.resp_data_o[31:0] <= bus.filereg_rdata_i;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready_i[gnt_q]) begin
            state      <= IDLE;
            resp_vld_q <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_noc_config_filereg_arbiter.sv
// Bench for noc_config_filereg_arbiter: cycle-schedule model plus directed vectors.
// Honours NOC_CONFIG_FILEREG_WRITE_ACK_EN when defined.
module tb_noc_config_filereg_arbiter;
  localparam int N  = 2;
  localparam int NR = 16;
  localparam int L  = 2;
`ifdef NOC_CONFIG_FILEREG_WRITE_ACK_EN
  localparam bit Ack = 1'b1;
`else
  localparam bit Ack = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] mod_addr = '0;
  logic        busy;
  logic        err;

  noc_config_filereg_arbiter_if #(.NumRequesters(N)) bus();

  noc_config_filereg_arbiter #(
    .NumRequesters(N),
    .NumRegisters (NR),
    .ReadLatency  (L)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .module_addr_i(mod_addr),
    .bus          (bus),
    .busy_o       (busy),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [38:0] mk(logic [1:0] c, logic [4:0] r,
                                     logic [31:0] p);
    return {c, r, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FileReg environment: memory with L-cycle read data, junk otherwise
  logic [31:0] env_mem [32];
  int          rd_due = -1;
  logic [31:0] rd_val = '0;

  always @(negedge clk) begin
    if (!rst && bus.filereg_we_o)
      env_mem[bus.filereg_addr_o] = bus.filereg_wdata_o;
    if (!rst && bus.filereg_re_o) begin
      rd_due = cyc + L;
      rd_val = env_mem[bus.filereg_addr_o];
    end
  end

  initial begin
    bus.filereg_rdata_i = 32'hDEADBEEF;
    forever begin
      step();
      bus.filereg_rdata_i = (cyc == rd_due) ? rd_val : 32'hDEADBEEF;
    end
  end

  // Model: schedules outputs in absolute cycle numbers per transaction
  int          m_ptr = 0;
  int          idle_from = 0;
  bit          resp_act = 0;
  int          resp_from = 0;
  int          resp_who = 0;
  logic [31:0] resp_dat = '0;
  logic [10:0] resp_mod = '0;
  int          iss_cyc = -1;
  bit          e_we, e_re, e_err;
  logic [4:0]  e_addr;
  logic [31:0] e_wdata;
  logic [31:0] shadow [32];

  always @(negedge clk) begin : model
    int          w;
    bit          idle;
    bit          rv;
    bit          iss;
    logic [38:0] msg;
    logic [1:0]  mc;
    logic [4:0]  mr;
    logic [31:0] mp;
    bit          inr;
    logic [N-1:0] erdy;
    if (rst) begin
      chk("rst_ctl", {bus.req_ready_o, bus.resp_valid_o,
          bus.filereg_we_o, bus.filereg_re_o, busy, err}, '0);
      chk("rst_data", {bus.resp_data_o, bus.filereg_addr_o,
          bus.filereg_wdata_o}, '0);
      m_ptr     = 0;
      idle_from = cyc + 1;
      resp_act  = 0;
      iss_cyc   = -1;
    end else begin
      idle = (cyc >= idle_from) && !resp_act;
      w = -1;
      if (idle)
        for (int i = 0; i < N; i++)
          if (w < 0 && bus.req_valid_i[(m_ptr + i) % N])
            w = (m_ptr + i) % N;
      erdy = '0;
      if (w >= 0) erdy[w] = 1'b1;
      chk("req_ready", bus.req_ready_o, erdy);
      chk("busy", busy, !idle);
      iss = (cyc == iss_cyc);
      chk("we", bus.filereg_we_o, iss && e_we);
      chk("re", bus.filereg_re_o, iss && e_re);
      chk("err", err, iss && e_err);
      if (iss && (e_we || e_re))
        chk("addr", bus.filereg_addr_o, e_addr);
      if (iss && e_we)
        chk("wdata", bus.filereg_wdata_o, e_wdata);
      if (iss) resp_mod = mod_addr;
      rv = resp_act && (cyc >= resp_from);
      chk("resp_valid", bus.resp_valid_o,
          rv ? (128'd1 << resp_who) : 128'd0);
      if (rv) begin
        chk("resp_data", bus.resp_data_o, {resp_mod, resp_dat});
        if (bus.resp_ready_i[resp_who]) begin
          resp_act  = 0;
          idle_from = cyc + 1;
        end
      end
      if (w >= 0) begin
        msg       = bus.req_data_i[w*39 +: 39];
        mc        = msg[38:37];
        mr        = msg[36:32];
        mp        = msg[31:0];
        inr       = int'(mr) < NR;
        m_ptr     = (w + 1) % N;
        iss_cyc   = cyc + 1;
        e_we      = (mc == 2'b00) && inr;
        e_re      = (mc == 2'b01) && inr;
        e_err     = mc[1] || !inr;
        e_addr    = mr;
        e_wdata   = mp;
        idle_from = cyc + 2;
        if (mc == 2'b01) begin
          resp_act  = 1;
          resp_who  = w;
          resp_from = inr ? cyc + 2 + L : cyc + 2;
          resp_dat  = inr ? shadow[mr] : 32'h0;
        end else if (mc == 2'b00) begin
          if (inr) shadow[mr] = mp;
          if (Ack) begin
            resp_act  = 1;
            resp_who  = w;
            resp_from = cyc + 2;
            resp_dat  = inr ? mp : 32'h0;
          end
        end
      end
    end
  end

  task automatic send(int k, logic [38:0] m);
    bus.req_valid_i[k] = 1'b1;
    bus.req_data_i[k*39 +: 39] = m;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.req_ready_o[k]) begin
        step();
        bus.req_valid_i[k] = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: requester %0d not accepted", k);
    bus.req_valid_i[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          gr [4];
    int          ngr;
    int          nresp;
    int          h;
    logic [N-1:0] nv;
    logic [N-1:0] nr;
    for (int i = 0; i < 32; i++) begin
      env_mem[i] = '0;
      shadow[i]  = '0;
    end
    bus.req_valid_i  = '0;
    bus.req_data_i   = '0;
    bus.resp_ready_i = '1;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst", {bus.req_ready_o, bus.resp_valid_o, busy, err,
        bus.filereg_we_o, bus.filereg_re_o}, '0);
    step();
    rst = 1'b0;
    step();

    // write from requester 0
    send(0, mk(2'b00, 5'd3, 32'hCAFE0001));
    @(negedge clk);
    chk("lit_wr_strobe", {bus.filereg_we_o, bus.filereg_re_o,
        bus.filereg_addr_o, bus.filereg_wdata_o},
        {1'b1, 1'b0, 5'd3, 32'hCAFE0001});
    chk("lit_wr_noresp", bus.resp_valid_o, 2'b00);
    step();

    // write then read reg 3 from requester 1
    mod_addr = 11'h155;
    send(1, mk(2'b00, 5'd3, 32'hCAFE0001));
    send(1, mk(2'b00, 5'd7, 32'h0BADF00D));
    send(1, mk(2'b01, 5'd3, 32'h0));
    step();
    step();
    @(negedge clk);
    chk("lit_rd_early", bus.resp_valid_o, 2'b00);
    step();
    @(negedge clk);
    chk("lit_rd_valid", bus.resp_valid_o, 2'b10);
    chk("lit_rd_data", bus.resp_data_o, {11'h155, 32'hCAFE0001});
    step();
    step();

    // both requesters read continuously; alternate grants
    bus.resp_ready_i = '0;
    bus.req_data_i[0 +: 39]  = mk(2'b01, 5'd3, 32'h0);
    bus.req_data_i[39 +: 39] = mk(2'b01, 5'd7, 32'h0);
    bus.req_valid_i = 2'b11;
    ngr = 0;
    nresp = 0;
    h = 0;
    for (int t = 0; t < 200 && nresp < 4; t++) begin
      @(negedge clk);
      nv = bus.req_valid_i;
      nr = bus.resp_ready_i;
      if (|(bus.req_ready_o & bus.req_valid_i) && ngr < 4) begin
        gr[ngr] = bus.req_ready_o[1] ? 1 : 0;
        ngr++;
        if (ngr == 4) nv = '0;
      end
      if (bus.resp_valid_o != '0) begin
        h++;
        if (|(bus.resp_ready_i & bus.resp_valid_o)) begin
          nresp++;
          h = 0;
          nr = '0;
        end else if (h == 2) begin
          nr = ~bus.resp_valid_o;
        end else if (h == 3) begin
          nr = bus.resp_valid_o;
        end
      end
      step();
      bus.req_valid_i  = nv;
      bus.resp_ready_i = nr;
    end
    chk("lit_alt_count", ngr, 4);
    chk("lit_alt_order", {gr[0][0], gr[1][0], gr[2][0], gr[3][0]},
        4'b0101);
    chk("lit_alt_resps", nresp, 4);
    bus.req_valid_i  = '0;
    bus.resp_ready_i = '1;
    step();

    // out-of-range read
    send(0, mk(2'b01, 5'd20, 32'h0));
    @(negedge clk);
    chk("lit_oor_strobe", {err, bus.filereg_re_o, bus.filereg_we_o},
        3'b100);
    step();
    @(negedge clk);
    chk("lit_oor_resp", {bus.resp_valid_o, bus.resp_data_o},
        {2'b01, 11'h155, 32'h0});
    step();

    // illegal command
    send(1, mk(2'b10, 5'd3, 32'h1));
    @(negedge clk);
    chk("lit_ill_strobe", {err, bus.filereg_re_o, bus.filereg_we_o},
        3'b100);
    step();
    @(negedge clk);
    chk("lit_ill_after", {bus.resp_valid_o, busy, err}, '0);
    step();

    // reset during WAIT, then fresh grant starts at requester 0
    send(0, mk(2'b01, 5'd3, 32'h0));
    step();
    rst = 1'b1;
    bus.req_data_i[39 +: 39] = mk(2'b01, 5'd7, 32'h0);
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    chk("lit_rst_wait", {bus.req_ready_o, bus.resp_valid_o, busy, err,
        bus.filereg_we_o, bus.filereg_re_o, bus.resp_data_o}, '0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_rst_rr0", bus.req_ready_o, 2'b01);
    step();
    bus.req_valid_i = '0;
    repeat (8) step();

`ifdef NOC_CONFIG_FILEREG_WRITE_ACK_EN
    // write acknowledge
    send(0, mk(2'b00, 5'd5, 32'h12345678));
    @(negedge clk);
    chk("lit_ack_we", bus.filereg_we_o, 1'b1);
    step();
    @(negedge clk);
    chk("lit_ack_resp", {bus.resp_valid_o, bus.resp_data_o},
        {2'b01, 11'h155, 32'h12345678});
    step();
`endif

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
